// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared TDM link constants and types for mux and demux sides
package tdm_pkg;

    localparam int NUM_CH = 8;
    localparam int SLOT_W = 3;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam slot_t LAST_SLOT = 3'd7;

    // Slot index advance; relies on the 3-bit width to wrap 7 -> 0.
    function automatic slot_t next_slot(input slot_t s);
        return s + 3'd1;
    endfunction

endpackage

// File: rtl/tdm_demux8_if.sv
// rtl/tdm_demux8_if.sv - serial TDM input and parallel frame output bundle
interface tdm_demux8_if
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0]        din;
    logic                    din_valid;
    logic                    frame_sync;
    logic [NUM_CH*WIDTH-1:0] dout;
    logic                    frame_valid;
    logic                    sync_err;
    logic                    locked;
    slot_t                   slot;

    modport master (
        output din, din_valid, frame_sync,
        input  dout, frame_valid, sync_err, locked, slot
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output dout, frame_valid, sync_err, locked, slot
    );
endinterface

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - wrapping slot counter with sync realignment and lock flag
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  accept,
    input  logic  sync,
    output slot_t slot,
    output logic  locked
);

    // A sync sample is always slot 0, so the next expected slot is 1;
    // without lock, unsynced samples are ignored and the count stays at 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot   <= '0;
            locked <= 1'b0;
        end else if (accept) begin
            if (sync) begin
                slot   <= 3'd1;
                locked <= 1'b1;
            end else if (locked) begin
                slot <= next_slot(slot);
            end
        end
    end

endmodule

// File: rtl/tdm_demux8.sv
// rtl/tdm_demux8.sv - eight-channel TDM deserialiser with coherent frame publish
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux8_if.slave   bus
);

    // Slots 0..6 are held here; slot 7 goes straight into dout with them.
    logic [NUM_CH-2:0][WIDTH-1:0] shadow;
    logic [NUM_CH*WIDTH-1:0]      dout_q;
    logic                         frame_valid_q;
    logic                         sync_err_q;
    slot_t                        slot;
    logic                         locked;
    logic                         accept;
    logic                         sync_acc;
    logic                         data_acc;
    logic                         complete;
    logic                         realign_err;

    assign accept      = bus.din_valid;
    assign sync_acc    = accept && bus.frame_sync;
    assign data_acc    = accept && !bus.frame_sync && locked;
    assign complete    = data_acc && (slot == LAST_SLOT);
    assign realign_err = sync_acc && locked && (slot != '0);

    tdm_slot_counter u_slot_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept),
        .sync   (bus.frame_sync),
        .slot   (slot),
        .locked (locked)
    );

    // Capture each accepted sample into its slot of the shadow frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (sync_acc) begin
            shadow[0] <= bus.din;
        end else if (data_acc && (slot != LAST_SLOT)) begin
            shadow[slot] <= bus.din;
        end
    end

    // Publish the completed frame and raise the one-cycle status strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            frame_valid_q <= complete;
            sync_err_q    <= realign_err;
            if (complete) begin
                dout_q <= {bus.din, shadow};
            end
        end
    end

    assign bus.dout        = dout_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.locked      = locked;
    assign bus.slot        = slot;

endmodule

// File: tb/tb_tdm_demux8.sv
// tb/tb_tdm_demux8.sv - self-checking bench for tdm_demux8 against a frame-assembly model
module tb_tdm_demux8;

    localparam int W = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;

    tdm_demux8_if #(.WIDTH(W)) bus ();

    tdm_demux8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Model: the partial frame is a queue of samples; next slot = its length.
    logic [W-1:0]   q[$];
    bit             m_locked = 1'b0;
    logic [8*W-1:0] m_dout = '0;
    bit             m_fv = 1'b0;
    bit             m_err = 1'b0;

    always @(posedge clk) begin
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_locked = 1'b0;
            m_dout   = '0;
        end else if (bus.din_valid) begin
            if (bus.frame_sync) begin
                if (m_locked && q.size() != 0) m_err = 1'b1;
                q.delete();
                q.push_back(bus.din);
                m_locked = 1'b1;
            end else if (m_locked) begin
                q.push_back(bus.din);
                if (q.size() == 8) begin
                    m_dout = '0;
                    foreach (q[k]) m_dout[k*W +: W] = q[k];
                    m_fv = 1'b1;
                    q.delete();
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    int fv_cycles[$];

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dout", 64'(bus.dout), 64'(m_dout));
            chk("frame_valid", 64'(bus.frame_valid), 64'(m_fv));
            chk("sync_err", 64'(bus.sync_err), 64'(m_err));
            chk("locked", 64'(bus.locked), 64'(m_locked));
            chk("slot", 64'(bus.slot), 64'(q.size() % 8));
            if (bus.frame_valid === 1'b1) fv_cycles.push_back(cyc);
        end
    end

    task automatic send(input logic [W-1:0] d, input logic s);
        bus.din        = d;
        bus.din_valid  = 1'b1;
        bus.frame_sync = s;
        @(posedge clk);
        #1;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sync_first);
        for (int i = 0; i < 8; i++) send(b[i], (i == 0) ? sync_first : 1'b0);
    endtask

    initial begin
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        rst_n          = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle(1);
        @(negedge clk);
        chk("reset dout", 64'(bus.dout), 64'h0);
        chk("reset locked", 64'(bus.locked), 64'h0);
        chk("reset slot", 64'(bus.slot), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Unsynced samples before lock are ignored.
        send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
        @(negedge clk);
        chk("prelock locked", 64'(bus.locked), 64'h0);
        chk("prelock slot", 64'(bus.slot), 64'h0);
        chk("prelock dout", 64'(bus.dout), 64'h0);

        // First sync frame: channels 1,0,1,0,1,0,1,0.
        send_byte(8'b0101_0101, 1'b1);
        @(negedge clk);
        chk("frame1 dout", 64'(bus.dout), 64'h55);
        chk("frame1 fv", 64'(bus.frame_valid), 64'h1);
        chk("frame1 locked", 64'(bus.locked), 64'h1);
        chk("frame1 slot", 64'(bus.slot), 64'h0);
        idle(1);
        @(negedge clk);
        chk("frame1 fv drop", 64'(bus.frame_valid), 64'h0);

        // Stall between slots 3 and 4; channels 1,1,0,0,1,1,0,0.
        send(1'b1, 1'b1); send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0);
        idle(3);
        @(negedge clk);
        chk("gap slot", 64'(bus.slot), 64'h4);
        send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0);
        @(negedge clk);
        chk("gap dout", 64'(bus.dout), 64'h33);

        // Unexpected sync at slot 5, then realign with seven ones.
        send(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        @(negedge clk);
        chk("err pulse", 64'(bus.sync_err), 64'h1);
        chk("err dout kept", 64'(bus.dout), 64'h33);
        for (int i = 0; i < 7; i++) send(1'b1, 1'b0);
        @(negedge clk);
        chk("realign dout", 64'(bus.dout), 64'hFF);

        // Back-to-back frames, the second free-running without sync.
        fv_cycles.delete();
        send_byte(8'hA5, 1'b1);
        @(negedge clk);
        chk("b2b first", 64'(bus.dout), 64'hA5);
        send_byte(8'h3C, 1'b0);
        @(negedge clk);
        chk("b2b second", 64'(bus.dout), 64'h3C);
        chk("b2b pulse count", 64'(fv_cycles.size()), 64'h2);
        if (fv_cycles.size() == 2)
            chk("b2b spacing", 64'(fv_cycles[1] - fv_cycles[0]), 64'h8);

        // Reset mid-frame at slot 4.
        send(1'b1, 1'b1); send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
        rst_n = 1'b0;
        idle(1);
        @(negedge clk);
        chk("midrst dout", 64'(bus.dout), 64'h0);
        chk("midrst locked", 64'(bus.locked), 64'h0);
        chk("midrst slot", 64'(bus.slot), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_byte(8'h0F, 1'b1);
        @(negedge clk);
        chk("post rst dout", 64'(bus.dout), 64'h0F);

        // Random traffic: stalls, occasional syncs, rare resets.
        for (int i = 0; i < 1500; i++) begin
            bus.din        = W'($urandom);
            bus.din_valid  = ($urandom_range(0, 3) != 0);
            bus.frame_sync = ($urandom_range(0, 11) == 0);
            rst_n          = ($urandom_range(0, 199) != 0);
            @(posedge clk);
            #1;
        end
        rst_n          = 1'b1;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Receive end of the 8:1 channel multiplexer link: recovers eight channels from a time-division-multiplexed serial stream.
- One sample per slot; slot 0 is marked by frame_sync.
- Deserialises slots 0..7 into a shadow register, then publishes a complete, coherent 8-channel word with a one-cycle frame_valid strobe.
- Sits after the mux/serial link, in front of per-channel consumers.

Parameters:
- WIDTH, 1, bits per channel sample.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- din  input  WIDTH  sample for the current slot.
- din_valid  input  1  din carries a slot sample this cycle; low = idle/stall.
- frame_sync  input  1  qualified by din_valid; marks the current sample as slot 0.
- dout  output  8*WIDTH  last complete frame; channel k at dout[k*WIDTH +: WIDTH].
- frame_valid  output  1  one-cycle pulse: dout just updated.
- sync_err  output  1  one-cycle pulse: frame_sync arrived at an unexpected slot.
- locked  output  1  alignment acquired.
- slot  output  3  index of the next expected slot.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n low at an edge) takes priority over all inputs, including mid-frame. Reset values:
  - dout = 0, frame_valid = 0, sync_err = 0, locked = 0, slot = 0, shadow = 0.
  - Any partial frame is lost.
- All outputs are registered. Effects of inputs sampled at edge N are visible after edge N.
- Accepted sample = din_valid high at the edge. With din_valid low, state holds and frame_valid/sync_err are 0.
- Unlocked (locked = 0):
  - Samples without frame_sync are ignored; slot stays 0.
  - A sample with frame_sync is slot 0: shadow[0] <= din, slot <= 1, locked <= 1.
- Locked, sample with frame_sync = 0:
  - shadow[slot] <= din, slot <= slot + 1 (3-bit wrap, 7 -> 0).
  - If slot == 7: dout <= {din, shadow[6:0]} and frame_valid <= 1 at the same edge. dout changes only on frame completion.
- Locked, sample with frame_sync = 1:
  - slot == 0: normal slot-0 capture, same as the unlocked case.
  - slot != 0: sync_err <= 1 for one cycle. Partial frame is discarded (dout untouched, no frame_valid). Realign: shadow[0] <= din, slot <= 1.
- A frame without frame_sync on its slot 0 (free-running after lock) is accepted. Alignment is trusted until contradicted; locked stays 1 until reset.
- Back-to-back frames with no idle: frame_valid pulses every 8 accepted samples, never held high for two consecutive cycles.
- Latency: slot-7 sample at edge N -> dout/frame_valid valid after edge N. Minimum frame period is 8 cycles.

Decomposition:
- Shared package tdm_pkg:
  - NUM_CH = 8, SLOT_W = 3.
  - Typedef slot_t (logic [2:0]).
  - Constant LAST_SLOT = 3'd7.
  - Used by both this block and the mux-side tdm serializer.
- One natural sub-module: tdm_slot_counter (wrapping slot counter with load-to-1 on sync, enable on accept, lock flag).
- Shadow/output registers stay in the top module.

Test Plan:
- Reset then sync frame with channels 1,0,1,0,1,0,1,0 (WIDTH = 1, frame_sync with the first) -> after the 8th accepted sample, dout = 8'b01010101, frame_valid high exactly one cycle, locked = 1, slot = 0.
- Samples 1,1,1 with no frame_sync before lock -> locked = 0, slot = 0, dout = 0, no frame_valid.
- din_valid low for 3 cycles between slots 3 and 4 of a frame with channels 0..7 = 1,1,0,0,1,1,0,0 -> dout = 8'b00110011 on completion; slot holds at 4 during the gap; frame_valid only at completion.
- Locked, frame_sync asserted at slot 5 -> sync_err pulses one cycle; prior dout unchanged; next 7 samples 1,1,1,1,1,1,1 with sync sample 1 -> dout = 8'hFF.
- Two back-to-back frames 8'hA5 then 8'h3C, no idle -> frame_valid pulses exactly 8 cycles apart; dout = 8'hA5 then 8'h3C.
- rst_n low at slot 4 mid-frame -> all outputs 0, locked = 0; a fresh sync frame of 8'h0F completes normally.
